// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals between the MEM stage, the
// load/store unit and the word-organised data memory.
interface load_store_unit_if #(
  parameter int address_bits = 12,
  parameter int data_width   = 32
);
  logic                    req_valid;
  logic                    req_write;
  logic [2:0]              req_funct3;
  logic [address_bits-1:0] req_addr;
  logic [data_width-1:0]   req_wdata;
  logic                    stall;
  logic                    done;
  logic [data_width-1:0]   rdata;
  logic                    fault;
  logic                    mem_write;
  logic [address_bits-1:0] mem_address;
  logic [data_width-1:0]   mem_write_data;
  logic [data_width-1:0]   mem_read_data;

  modport master (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    output stall, done, rdata, fault, mem_write, mem_address, mem_write_data
  );

  modport slave (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    input  stall, done, rdata, fault, mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: byte/half/word loads with extension, word stores
// direct, sub-word stores as read-modify-write against a synchronous-read memory.
module load_store_unit #(
  parameter int address_bits = 12,
  parameter int data_width   = 32
) (
  input logic               clk,
  input logic               rst_n,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_MERGE} state_t;

  state_t     state;
  logic [1:0] offset;
  logic [2:0] f3;
  logic       legal_load, legal_store, misaligned, bad_req, is_sw;

  function automatic logic [data_width-1:0] format_load(
    input logic [data_width-1:0] word,
    input logic [1:0]            off,
    input logic [2:0]            funct3
  );
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    lane_b = word[8*off +: 8];
    lane_h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  format_load = data_width'(lane_b);
      3'b001:  format_load = data_width'(lane_h);
      3'b100:  format_load = data_width'($unsigned(lane_b));
      3'b101:  format_load = data_width'($unsigned(lane_h));
      default: format_load = word;
    endcase
  endfunction

  function automatic logic [data_width-1:0] merge_store(
    input logic [data_width-1:0] word,
    input logic [1:0]            off,
    input logic [2:0]            funct3,
    input logic [data_width-1:0] wdata
  );
    logic [data_width-1:0] merged;
    merged = word;
    if (funct3[0] == 1'b0)
      merged[8*off +: 8] = wdata[7:0];
    else if (off[1])
      merged[31:16] = wdata[15:0];
    else
      merged[15:0] = wdata[15:0];
    merge_store = merged;
  endfunction

  always_comb begin
    f3          = bus.req_funct3;
    offset      = bus.req_addr[1:0];
    legal_load  = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    legal_store = f3 inside {3'b000, 3'b001, 3'b010};
    misaligned  = ((f3[1:0] == 2'b01) && offset[0]) ||
                  ((f3[1:0] == 2'b10) && (offset != 2'b00));
    bad_req     = misaligned || (bus.req_write ? !legal_store : !legal_load);
    is_sw       = bus.req_write && (f3 == 3'b010);
  end

  // State register; only IDLE can start an access, every other state returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && !bad_req && !is_sw)
            state <= bus.req_write ? RMW_MERGE : LOAD_WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_address = bus.req_addr;

  // Outputs follow state and request; a dropped req_valid mid-access is a flush
  always_comb begin
    bus.mem_write      = 1'b0;
    bus.mem_write_data = '0;
    bus.done           = 1'b0;
    bus.fault          = 1'b0;
    bus.stall          = 1'b0;
    bus.rdata          = '0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (bad_req) begin
            bus.done  = 1'b1;
            bus.fault = 1'b1;
          end else if (is_sw) begin
            bus.mem_write      = 1'b1;
            bus.mem_write_data = bus.req_wdata;
            bus.done           = 1'b1;
          end else begin
            bus.stall = 1'b1;
          end
        end
      end
      LOAD_WAIT: begin
        if (bus.req_valid) begin
          bus.done  = 1'b1;
          bus.rdata = format_load(bus.mem_read_data, offset, f3);
        end
      end
      RMW_MERGE: begin
        if (bus.req_valid) begin
          bus.done           = 1'b1;
          bus.mem_write      = 1'b1;
          bus.mem_write_data = merge_store(bus.mem_read_data, offset, f3, bus.req_wdata);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed spec scenarios plus randomized requests
// checked against an arithmetic reference model of the data memory.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.address_bits(12), .data_width(32)) bus ();

  load_store_unit #(.address_bits(12), .data_width(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  logic [31:0] mem [0:1023];
  logic [31:0] model_mem [0:1023];
  int n_checks = 0;
  int n_pass = 0;

  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_address[11:2]] <= bus.mem_write_data;
    else               bus.mem_read_data <= mem[bus.mem_address[11:2]];
  end

  // Results of one request as seen on the bus
  int          r_lat;
  logic [31:0] r_rdata, r_mwd;
  logic        r_fault, r_mw_done, r_mw_first, r_stall_first;

  task automatic run_req(input logic w, input logic [2:0] f3, input logic [11:0] addr,
                         input logic [31:0] wdata);
    bit got;
    got = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    r_lat = -1; r_rdata = 'x; r_mwd = 'x; r_fault = 1'bx; r_mw_done = 1'bx;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      if (c == 0) begin r_mw_first = bus.mem_write; r_stall_first = bus.stall; end
      if (bus.done) begin
        got = 1; r_lat = c + 1; r_rdata = bus.rdata; r_fault = bus.fault;
        r_mw_done = bus.mem_write; r_mwd = bus.mem_write_data;
      end
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Reference: expected outcome of one request from the ISA rules, updates model_mem
  task automatic model_req(input logic w, input logic [2:0] f3, input logic [11:0] addr,
                           input logic [31:0] wdata, output bit e_fault, output int e_lat,
                           output logic [31:0] e_rdata, output logic [31:0] e_word);
    int size, off;
    bit legal;
    logic [31:0] word, v, mask;
    off = int'(addr) % 4;
    size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    legal = w ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    e_fault = !legal || (size == 2 && (off % 2) != 0) || (size == 4 && off != 0);
    e_lat = (e_fault || (w && f3 == 3'd2)) ? 1 : 2;
    word = model_mem[addr / 4];
    e_rdata = 32'h0;
    e_word = word;
    if (!e_fault && !w) begin
      v = word >> (8 * off);
      if (size == 1) begin
        v = v & 32'hFF;
        if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFFFF00;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF0000;
      end
      e_rdata = v;
    end else if (!e_fault && w) begin
      mask = (size == 4) ? 32'hFFFFFFFF : (((32'h1 << (8 * size)) - 1) << (8 * off));
      e_word = (word & ~mask) | ((wdata << (8 * off)) & mask);
      model_mem[addr / 4] = e_word;
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = '0; bus.req_wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.stall !== 1'b0) $display("FAIL reset_stall got %b want 0", bus.stall); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.fault !== 1'b0) $display("FAIL reset_fault got %b want 0", bus.fault); else n_pass++;
    n_checks++; if (bus.mem_write !== 1'b0) $display("FAIL reset_mem_write got %b want 0", bus.mem_write); else n_pass++;
    n_checks++; if (bus.rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", bus.rdata); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [4] = '{3'b000, 3'b101, 3'b001, 3'b010};
    logic [11:0] ads [4] = '{12'h101, 12'h102, 12'h102, 12'h100};
    logic [31:0] exp [4] = '{32'hFFFFFFAA, 32'h00008899, 32'hFFFF8899, 32'h8899AABB};
    mem[12'h100 >> 2] = 32'h8899AABB;
    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, f3s[i], ads[i], 32'h0);
      n_checks++; if (r_lat !== 2) $display("FAIL load%0d_latency got %0d want 2", i, r_lat); else n_pass++;
      n_checks++; if (r_rdata !== exp[i]) $display("FAIL load%0d_rdata got %h want %h", i, r_rdata, exp[i]); else n_pass++;
      n_checks++; if (r_fault !== 1'b0) $display("FAIL load%0d_fault got %b want 0", i, r_fault); else n_pass++;
    end
    n_checks++; if (r_stall_first !== 1'b1) $display("FAIL load_stall got %b want 1", r_stall_first); else n_pass++;
  endtask

  task automatic test_sub_word_store();
    run_req(1'b1, 3'b000, 12'h103, 32'h12345677);
    n_checks++; if (r_mw_first !== 1'b0) $display("FAIL sb_first_mem_write got %b want 0", r_mw_first); else n_pass++;
    n_checks++; if (r_lat !== 2) $display("FAIL sb_latency got %0d want 2", r_lat); else n_pass++;
    n_checks++; if (r_mw_done !== 1'b1) $display("FAIL sb_mem_write got %b want 1", r_mw_done); else n_pass++;
    n_checks++; if (r_mwd !== 32'h7799AABB) $display("FAIL sb_merge got %h want 7799aabb", r_mwd); else n_pass++;
    run_req(1'b0, 3'b010, 12'h100, 32'h0);
    n_checks++; if (r_rdata !== 32'h7799AABB) $display("FAIL sb_readback got %h want 7799aabb", r_rdata); else n_pass++;
  endtask

  task automatic test_store_word();
    run_req(1'b1, 3'b010, 12'h104, 32'hDEADBEEF);
    n_checks++; if (r_lat !== 1) $display("FAIL sw_latency got %0d want 1", r_lat); else n_pass++;
    n_checks++; if (r_mw_done !== 1'b1) $display("FAIL sw_mem_write got %b want 1", r_mw_done); else n_pass++;
    n_checks++; if (r_stall_first !== 1'b0) $display("FAIL sw_stall got %b want 0", r_stall_first); else n_pass++;
    n_checks++; if (r_mwd !== 32'hDEADBEEF) $display("FAIL sw_wdata got %h want deadbeef", r_mwd); else n_pass++;
    run_req(1'b0, 3'b010, 12'h104, 32'h0);
    n_checks++; if (r_rdata !== 32'hDEADBEEF) $display("FAIL sw_readback got %h want deadbeef", r_rdata); else n_pass++;
  endtask

  task automatic test_faults();
    logic        ws  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s [5] = '{3'b010, 3'b001, 3'b011, 3'b101, 3'b100};
    logic [11:0] ads [5] = '{12'h102, 12'h105, 12'h100, 12'h103, 12'h104};
    for (int i = 0; i < 5; i++) begin
      run_req(ws[i], f3s[i], ads[i], 32'hCAFEF00D);
      n_checks++; if (r_lat !== 1) $display("FAIL fault%0d_latency got %0d want 1", i, r_lat); else n_pass++;
      n_checks++; if (r_fault !== 1'b1) $display("FAIL fault%0d_flag got %b want 1", i, r_fault); else n_pass++;
      n_checks++; if (r_mw_first !== 1'b0) $display("FAIL fault%0d_mem_write got %b want 0", i, r_mw_first); else n_pass++;
    end
    n_checks++; if (mem[12'h104 >> 2] !== 32'hDEADBEEF) $display("FAIL fault_mem got %h want deadbeef", mem[12'h104 >> 2]); else n_pass++;
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 12'h100; bus.req_wdata = 32'h55;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    #1;
    n_checks++; if (bus.mem_write !== 1'b0) $display("FAIL flush_mem_write got %b want 0", bus.mem_write); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL flush_done got %b want 0", bus.done); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (mem[12'h100 >> 2] !== 32'h7799AABB) $display("FAIL flush_mem got %h want 7799aabb", mem[12'h100 >> 2]); else n_pass++;
    run_req(1'b0, 3'b100, 12'h101, 32'h0);
    n_checks++; if (r_rdata !== 32'h000000AA) $display("FAIL after_flush_rdata got %h want 000000aa", r_rdata); else n_pass++;
  endtask

  task automatic test_reset_mid_rmw();
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b001;
    bus.req_addr = 12'h100; bus.req_wdata = 32'h0000BEEF;
    @(posedge clk); #2;
    n_checks++; if (bus.mem_write !== 1'b1) $display("FAIL rmw_before_reset got %b want 1", bus.mem_write); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.mem_write !== 1'b0) $display("FAIL rmw_reset_mem_write got %b want 0", bus.mem_write); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL rmw_reset_done got %b want 0", bus.done); else n_pass++;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.stall !== 1'b0 || bus.done !== 1'b0) $display("FAIL rmw_after_reset stall/done got %b%b want 00", bus.stall, bus.done); else n_pass++;
    n_checks++; if (mem[12'h100 >> 2] !== 32'h7799AABB) $display("FAIL rmw_reset_mem got %h want 7799aabb", mem[12'h100 >> 2]); else n_pass++;
  endtask

  task automatic test_random();
    logic        w;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] wdata, e_rdata, e_word;
    bit          e_fault;
    int          e_lat;
    for (int i = 0; i < 1024; i++) model_mem[i] = mem[i];
    for (int i = 0; i < 60; i++) begin
      w     = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      addr  = 12'h100 + 12'($urandom_range(0, 31));
      wdata = $urandom;
      model_req(w, f3, addr, wdata, e_fault, e_lat, e_rdata, e_word);
      run_req(w, f3, addr, wdata);
      n_checks++; if (r_lat !== e_lat) $display("FAIL rand%0d_latency got %0d want %0d", i, r_lat, e_lat); else n_pass++;
      n_checks++; if (r_fault !== e_fault) $display("FAIL rand%0d_fault got %b want %b", i, r_fault, e_fault); else n_pass++;
      if (!e_fault && !w) begin
        n_checks++; if (r_rdata !== e_rdata) $display("FAIL rand%0d_rdata got %h want %h", i, r_rdata, e_rdata); else n_pass++;
      end
      if (!e_fault && w) begin
        n_checks++; if (r_mwd !== e_word) $display("FAIL rand%0d_wdata got %h want %h", i, r_mwd, e_word); else n_pass++;
      end
      n_checks++; if (mem[addr[11:2]] !== model_mem[addr[11:2]]) $display("FAIL rand%0d_mem got %h want %h", i, mem[addr[11:2]], model_mem[addr[11:2]]); else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    test_reset();
    test_loads();
    test_sub_word_store();
    test_store_word();
    test_faults();
    test_flush();
    test_reset_mid_rmw();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
